// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl
//   Packet-level controller behind a byte-oriented UART receiver.
//
//   Frame format on the wire is:
//     SYNC, LEN, LEN payload bytes [, CHK]
//
//   The block hunts for the SYNC byte and then collects the length-prefixed
//   payload into an internal buffer. A complete frame is released on a
//   valid/ready byte stream, so downstream logic only ever sees complete,
//   checked frames.
//
//   Optional feature macro: UART_PKT_CHECKSUM_EN
//     Defined   : a trailing XOR checksum byte (LEN ^ payload) is expected.
//                 A mismatch pulses o_err_chk.
//     Undefined : there is no checksum byte on the wire, and o_err_chk is
//                 tied low.
//
// Ports
//   i_clk, i_rstn    clock and synchronous active-low reset
//   o_rx_en          enable for the receiver start detector (low while
//                    draining a frame)
//   i_rx_done        one-cycle byte strobe from the receiver
//   i8_rx_data       byte qualified by i_rx_done
//   o_valid, o8_data, o_last, i_ready
//                    payload stream
//   o8_len           length of the frame being streamed
//   o_err_len        one-cycle error pulse: illegal length byte
//   o_err_chk        one-cycle error pulse: checksum mismatch
//   o_err_tmo        one-cycle error pulse: inter-byte timeout
//   o_busy           high whenever the controller is not hunting for SYNC
module uart_rx_pkt_ctrl #(
  parameter int         p_MAX_LEN     = 16,
  parameter logic [7:0] p_SYNC        = 8'hA5,
  parameter int         p_TIMEOUT_CYC = 125_000
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  output logic       o_rx_en,
  input  logic       i_rx_done,
  input  logic [7:0] i8_rx_data,
  output logic       o_valid,
  output logic [7:0] o8_data,
  output logic       o_last,
  input  logic       i_ready,
  output logic [7:0] o8_len,
  output logic       o_err_len,
  output logic       o_err_chk,
  output logic       o_err_tmo,
  output logic       o_busy
);

  localparam int IDX_W = $clog2(p_MAX_LEN + 1);
  localparam int AW    = (p_MAX_LEN > 1) ? $clog2(p_MAX_LEN) : 1;
  localparam int TMO_W = $clog2(p_TIMEOUT_CYC);

  localparam logic [7:0]       MAX_LEN8 = 8'(p_MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(p_TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             wr_en;
  logic             idx_is_last;
  logic             err_len_d, err_tmo_d;
  logic [AW-1:0]    rd_addr;
  logic [7:0]       rd_data;

  logic [7:0] buf_mem [0:p_MAX_LEN-1];

  logic       o_rx_en_q, o_valid_q, o_last_q, o_busy_q;
  logic       o_err_len_q, o_err_tmo_q;
  logic [7:0] o8_data_q, o8_len_q;

`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
  logic       err_chk_d, o_err_chk_q;
`endif

  assign idx_is_last = (8'(idx_q) == len_q - 8'd1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    wr_en     = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
    chk_d     = chk_q;
    err_chk_d = 1'b0;
`endif

    // The timeout only runs while the frame is being received. A byte in
    // the same cycle as expiry wins, because it clears the counter first.
    if (state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHK) begin
      if (i_rx_done) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        err_tmo_d = 1'b1;
        state_d   = S_HUNT;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    case (state_q)
      S_HUNT: begin
        tmo_d = '0;
        if (i_rx_done && i8_rx_data == p_SYNC) state_d = S_LEN;
      end
      S_LEN: begin
        if (i_rx_done) begin
          if (i8_rx_data != 8'd0 && i8_rx_data <= MAX_LEN8) begin
            len_d   = i8_rx_data;
            idx_d   = '0;
            state_d = S_PAYLOAD;
`ifdef UART_PKT_CHECKSUM_EN
            chk_d   = i8_rx_data;
`endif
          end else begin
            err_len_d = 1'b1;
            state_d   = S_HUNT;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_rx_done) begin
          wr_en = 1'b1;
          idx_d = idx_q + IDX_W'(1);
`ifdef UART_PKT_CHECKSUM_EN
          chk_d = chk_q ^ i8_rx_data;
          if (idx_is_last) state_d = S_CHK;
`else
          if (idx_is_last) begin
            state_d = S_OUT;
            idx_d   = '0;
          end
`endif
        end
      end
      S_CHK: begin
`ifdef UART_PKT_CHECKSUM_EN
        if (i_rx_done) begin
          if (i8_rx_data == chk_q) begin
            state_d = S_OUT;
            idx_d   = '0;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_HUNT;
          end
        end
`else
        state_d = S_HUNT;
`endif
      end
      S_OUT: begin
        // o_valid is always high in this state, so i_ready alone marks a
        // handshake. Bytes strobed by the receiver here are dropped.
        if (i_ready) begin
          if (idx_is_last) state_d = S_HUNT;
          else             idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  // The read address follows the next index so that o8_data is registered
  // alongside o_valid. The bypass covers a one-byte frame without a checksum:
  // in that case, buf[0] is written in the same cycle that OUT is entered.
  assign rd_addr = idx_d[AW-1:0];
  assign rd_data = (wr_en && idx_q[AW-1:0] == rd_addr) ? i8_rx_data
                                                       : buf_mem[rd_addr];

  always_ff @(posedge i_clk) begin
    if (wr_en) buf_mem[idx_q[AW-1:0]] <= i8_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= S_HUNT;
      len_q       <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      o_rx_en_q   <= 1'b0;
      o_valid_q   <= 1'b0;
      o_last_q    <= 1'b0;
      o8_data_q   <= '0;
      o8_len_q    <= '0;
      o_err_len_q <= 1'b0;
      o_err_tmo_q <= 1'b0;
      o_busy_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      o_rx_en_q   <= (state_d != S_OUT);
      o_valid_q   <= (state_d == S_OUT);
      o_last_q    <= (state_d == S_OUT) && (8'(idx_d) == len_d - 8'd1);
      o8_data_q   <= rd_data;
      o8_len_q    <= len_d;
      o_err_len_q <= err_len_d;
      o_err_tmo_q <= err_tmo_d;
      o_busy_q    <= (state_d != S_HUNT);
    end
  end

`ifdef UART_PKT_CHECKSUM_EN
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      chk_q       <= '0;
      o_err_chk_q <= 1'b0;
    end else begin
      chk_q       <= chk_d;
      o_err_chk_q <= err_chk_d;
    end
  end
  assign o_err_chk = o_err_chk_q;
`else
  assign o_err_chk = 1'b0;
`endif

  assign o_rx_en   = o_rx_en_q;
  assign o_valid   = o_valid_q;
  assign o8_data   = o8_data_q;
  assign o_last    = o_last_q;
  assign o8_len    = o8_len_q;
  assign o_err_len = o_err_len_q;
  assign o_err_tmo = o_err_tmo_q;
  assign o_busy    = o_busy_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb_uart_rx_pkt_ctrl
//   Scoreboard bench for uart_rx_pkt_ctrl.
//
//   The stimulus process queues the expected payload bytes and error codes
//   before driving each frame. A negedge monitor pops and compares those
//   entries whenever the DUT hands over a byte or pulses an error.
//
//   Frames carry a checksum byte only when UART_PKT_CHECKSUM_EN is defined.
module tb_uart_rx_pkt_ctrl;

  localparam int TMO = 64;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_rx_done = 1'b0;
  logic [7:0] i8_rx_data = 8'h00;
  logic       i_ready = 1'b1;
  logic       o_rx_en, o_valid, o_last, o_err_len, o_err_chk, o_err_tmo, o_busy;
  logic [7:0] o8_data, o8_len;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic [7:0] len;
  } exp_t;

  exp_t       exp_q[$];
  int         err_q[$];   // 1 = length, 2 = checksum, 3 = timeout
  int         checks = 0;
  int         failures = 0;
  logic       toggle_ready = 1'b0;
  logic [7:0] pl [0:15];
  int         prev_err = 0;

  uart_rx_pkt_ctrl #(
    .p_MAX_LEN(16),
    .p_SYNC(8'hA5),
    .p_TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk(i_clk),
    .i_rstn(i_rstn),
    .o_rx_en(o_rx_en),
    .i_rx_done(i_rx_done),
    .i8_rx_data(i8_rx_data),
    .o_valid(o_valid),
    .o8_data(o8_data),
    .o_last(o_last),
    .i_ready(i_ready),
    .o8_len(o8_len),
    .o_err_len(o_err_len),
    .o_err_chk(o_err_chk),
    .o_err_tmo(o_err_tmo),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // i_ready is owned by this process: it is held high, or it alternates
  // every cycle when toggle_ready is set.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (toggle_ready) i_ready = ~i_ready;
      else              i_ready = 1'b1;
    end
  end

  // Monitor
  always @(negedge i_clk) begin
    int code;
    code = 0;
    if (o_valid && i_ready) begin
      check_eq("rx_en_low_in_out", {31'd0, o_rx_en}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte actual=%0h required=none", o8_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("OUT data=%02h last=%0d len=%0d", o8_data, o_last, o8_len);
        check_eq("out_data", {24'd0, o8_data}, {24'd0, e.d});
        check_eq("out_last", {31'd0, o_last}, {31'd0, e.last});
        check_eq("out_len", {24'd0, o8_len}, {24'd0, e.len});
      end
    end
    if (o_err_len) code = 1;
    if (o_err_chk) code = (code != 0) ? 9 : 2;
    if (o_err_tmo) code = (code != 0) ? 9 : 3;
    if (code != 0) begin
      $display("ERR code=%0d busy=%0d", code, o_busy);
      check_eq("err_busy_low", {31'd0, o_busy}, 32'd0);
      check_eq("err_single_cycle", prev_err, 0);
      if (err_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_error actual=%0d required=none", code);
      end else begin
        check_eq("err_kind", code, err_q.pop_front());
      end
    end
    prev_err = code;
  end

  // Entry and exit of every stimulus task is 1 time unit after a posedge.
  task automatic send_byte(input logic [7:0] b);
    i_rx_done = 1'b1;
    i8_rx_data = b;
    @(posedge i_clk);
    #1;
    i_rx_done = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input int n);
`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0] c;
    c = 8'(n);
`endif
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{d: pl[i], last: (i == n - 1), len: 8'(n)});
    end
    send_byte(8'hA5);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      send_byte(pl[i]);
`ifdef UART_PKT_CHECKSUM_EN
      c = c ^ pl[i];
`endif
    end
`ifdef UART_PKT_CHECKSUM_EN
    send_byte(c);
`endif
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0 && err_q.size() == 0 && !o_busy) break;
      @(posedge i_clk);
      #1;
    end
    check_eq({name, "_drained"}, exp_q.size() + err_q.size(), 0);
    check_eq({name, "_idle"}, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_rx_en"}, {31'd0, o_rx_en}, 32'd0);
    check_eq({name, "_valid"}, {31'd0, o_valid}, 32'd0);
    check_eq({name, "_last"}, {31'd0, o_last}, 32'd0);
    check_eq({name, "_data"}, {24'd0, o8_data}, 32'd0);
    check_eq({name, "_len"}, {24'd0, o8_len}, 32'd0);
    check_eq({name, "_errs"}, {29'd0, o_err_len, o_err_chk, o_err_tmo}, 32'd0);
    check_eq({name, "_busy"}, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs("reset");
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    check_eq("rx_en_after_reset", {31'd0, o_rx_en}, 32'd1);

    // Basic 3-byte frame (checksum 0x03 when enabled).
    pl[0] = 8'h11;
    pl[1] = 8'h22;
    pl[2] = 8'h33;
    send_frame(3);
    wait_idle("frame3");

`ifdef UART_PKT_CHECKSUM_EN
    // Wrong checksum: 0x04 instead of 0x03.
    err_q.push_back(2);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h04);
    wait_idle("badchk");
`endif

    // Illegal lengths 0 and 17.
    err_q.push_back(1);
    send_byte(8'hA5);
    send_byte(8'h00);
    err_q.push_back(1);
    send_byte(8'hA5);
    send_byte(8'h11);
    wait_idle("badlen");

    // Timeout mid-payload, then a frame whose payload contains the SYNC value.
    err_q.push_back(3);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    repeat (TMO + 10) @(posedge i_clk);
    #1;
    wait_idle("timeout");
    pl[0] = 8'hA5;
    pl[1] = 8'h44;
    send_frame(2);
    wait_idle("after_tmo");

    // Maximum-length frame with a stalling sink.
    for (int i = 0; i < 16; i++) pl[i] = 8'hC0 + 8'(i);
    toggle_ready = 1'b1;
    send_frame(16);
    wait_idle("frame16");
    toggle_ready = 1'b0;

    // Reset mid-frame drops the frame without an error pulse.
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h11);
    i_rstn = 1'b0;
    @(posedge i_clk);
    #1;
    check_reset_outputs("midreset");
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    pl[0] = 8'h7E;
    send_frame(1);
    wait_idle("after_reset");

    check_eq("final_queues", exp_q.size() + err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
